// File: rtl/fifo_chk_pkg.sv
// Shared types and err_mask bit positions for the FIFO shadow checker.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ERR_MASK_W  = 8;
  localparam int unsigned ERR_DOUT    = 0;
  localparam int unsigned ERR_FULL    = 1;
  localparam int unsigned ERR_AFULL   = 2;
  localparam int unsigned ERR_EMPTY   = 3;
  localparam int unsigned ERR_AEMPTY  = 4;
  localparam int unsigned ERR_OVF     = 5;
  localparam int unsigned ERR_UDF     = 6;
  localparam int unsigned ERR_WRACK   = 7;

endpackage

// File: rtl/fifo_shadow_model.sv
// Shadow reference model of a synchronous FIFO: storage, pointers, occupancy,
// expected registered outputs and expected occupancy flags.
module fifo_shadow_model #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_TH      = FIFO_DEPTH - 1,
  parameter int unsigned AE_TH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] exp_data_out,
  output logic                  exp_dout_vld,
  output logic                  exp_full,
  output logic                  exp_almostfull,
  output logic                  exp_empty,
  output logic                  exp_almostempty,
  output logic                  exp_overflow,
  output logic                  exp_underflow,
  output logic                  exp_wr_ack
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d, ack_q, ack_d;
  logic                  wr_ok, rd_ok;

  assign wr_ok = wr_en && (occ_q != OCC_W'(FIFO_DEPTH));
  assign rd_ok = rd_en && (occ_q != '0);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    dout_d     = dout_q;
    dout_vld_d = rd_ok;
    ovf_d      = wr_en && !wr_ok;
    udf_d      = rd_en && !rd_ok;
    ack_d      = wr_ok;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wr_ok && !rd_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (rd_ok && !wr_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Storage is not reset; a word is only compared after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      ack_q      <= ack_d;
    end
  end

  assign exp_data_out    = dout_q;
  assign exp_dout_vld    = dout_vld_q;
  assign exp_overflow    = ovf_q;
  assign exp_underflow   = udf_q;
  assign exp_wr_ack      = ack_q;
  assign exp_full        = (occ_q == OCC_W'(FIFO_DEPTH));
  assign exp_almostfull  = (occ_q == OCC_W'(AF_TH));
  assign exp_empty       = (occ_q == '0);
  assign exp_almostempty = (occ_q == OCC_W'(AE_TH));

endmodule

// File: rtl/fifo_shadow_checker.sv
// FIFO checker: compares observed FIFO outputs to a shadow model, counts results.
// Define FIFO_CHK_FIRST_ERR_EN to build first-error cycle/mask capture.
module fifo_shadow_checker
  import fifo_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_TH      = FIFO_DEPTH - 1,
  parameter int unsigned AE_TH      = 1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  almostfull,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  wr_ack,
  input  logic                  chk_en,
  input  logic                  test_end,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  err_valid,
  output logic [7:0]            err_mask,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  first_err_cycle,
  output logic [7:0]            first_err_mask
);

  logic [DATA_WIDTH-1:0] exp_data_out;
  logic exp_dout_vld, exp_full, exp_almostfull, exp_empty, exp_almostempty;
  logic exp_overflow, exp_underflow, exp_wr_ack;

  fifo_shadow_model #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AF_TH     (AF_TH),
    .AE_TH     (AE_TH)
  ) u_model (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .data_in        (data_in),
    .exp_data_out   (exp_data_out),
    .exp_dout_vld   (exp_dout_vld),
    .exp_full       (exp_full),
    .exp_almostfull (exp_almostfull),
    .exp_empty      (exp_empty),
    .exp_almostempty(exp_almostempty),
    .exp_overflow   (exp_overflow),
    .exp_underflow  (exp_underflow),
    .exp_wr_ack     (exp_wr_ack)
  );

  state_e                 state_q, state_d;
  logic [ERR_MASK_W-1:0]  mask;
  logic                   run_cmp;
  logic [CNT_WIDTH-1:0]   correct_q, correct_d, error_q, error_d;
  logic                   err_valid_q, err_valid_d;
  logic [ERR_MASK_W-1:0]  err_mask_q, err_mask_d;

  always_comb begin
    mask             = '0;
    mask[ERR_DOUT]   = exp_dout_vld && (data_out != exp_data_out);
    mask[ERR_FULL]   = (full        != exp_full);
    mask[ERR_AFULL]  = (almostfull  != exp_almostfull);
    mask[ERR_EMPTY]  = (empty       != exp_empty);
    mask[ERR_AEMPTY] = (almostempty != exp_almostempty);
    mask[ERR_OVF]    = (overflow    != exp_overflow);
    mask[ERR_UDF]    = (underflow   != exp_underflow);
    mask[ERR_WRACK]  = (wr_ack      != exp_wr_ack);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (test_end) state_d = DONE; else if (chk_en) state_d = RUN;
      RUN:     if (test_end) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  assign run_cmp = (state_q == RUN);

  always_comb begin
    correct_d   = correct_q;
    error_d     = error_q;
    err_valid_d = 1'b0;
    err_mask_d  = '0;
    if (run_cmp) begin
      if (mask == '0) begin
        if (correct_q != '1) correct_d = correct_q + CNT_WIDTH'(1);
      end else begin
        err_valid_d = 1'b1;
        err_mask_d  = mask;
        if (error_q != '1) error_d = error_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      correct_q   <= '0;
      error_q     <= '0;
      err_valid_q <= 1'b0;
      err_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      correct_q   <= correct_d;
      error_q     <= error_d;
      err_valid_q <= err_valid_d;
      err_mask_q  <= err_mask_d;
    end
  end

  assign correct_count = correct_q;
  assign error_count   = error_q;
  assign err_valid     = err_valid_q;
  assign err_mask      = err_mask_q;
  assign done          = (state_q == DONE);

`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [CNT_WIDTH-1:0]  run_cyc_q, run_cyc_d, fe_cyc_q, fe_cyc_d;
  logic [ERR_MASK_W-1:0] fe_mask_q, fe_mask_d;
  logic                  fe_seen_q, fe_seen_d;

  // run_cyc_q is the 0-based index of the RUN compare being made this cycle.
  always_comb begin
    run_cyc_d = run_cyc_q;
    fe_cyc_d  = fe_cyc_q;
    fe_mask_d = fe_mask_q;
    fe_seen_d = fe_seen_q;
    if (run_cmp) begin
      if (run_cyc_q != '1) run_cyc_d = run_cyc_q + CNT_WIDTH'(1);
      if (!fe_seen_q && (mask != '0)) begin
        fe_seen_d = 1'b1;
        fe_cyc_d  = run_cyc_q;
        fe_mask_d = mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cyc_q <= '0;
      fe_cyc_q  <= '0;
      fe_mask_q <= '0;
      fe_seen_q <= 1'b0;
    end else begin
      run_cyc_q <= run_cyc_d;
      fe_cyc_q  <= fe_cyc_d;
      fe_mask_q <= fe_mask_d;
      fe_seen_q <= fe_seen_d;
    end
  end

  assign first_err_cycle = fe_cyc_q;
  assign first_err_mask  = fe_mask_q;
`else
  assign first_err_cycle = '0;
  assign first_err_mask  = '0;
`endif

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Bench for fifo_shadow_checker: a behavioural FIFO with fault injection
// drives the checker; expected checker results are queued per cycle.
module tb_fifo_shadow_checker;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 32;

  typedef enum int {B_IDLE, B_RUN, B_DONE} bst_e;
  typedef struct {
    logic          ev;
    logic [7:0]    em;
    logic [CW-1:0] cor;
    logic [CW-1:0] err;
    logic          dn;
    logic [CW-1:0] fc;
    logic [7:0]    fm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_en = 1'b0, rd_en = 1'b0, chk_en = 1'b0, test_end = 1'b0;
  logic          inj_dout = 1'b0, inj_ovf = 1'b0;
  logic [DW-1:0] data_out;
  logic          full, almostfull, empty, almostempty, overflow, underflow, wr_ack;
  logic [CW-1:0] correct_count, error_count, first_err_cycle;
  logic          err_valid, done;
  logic [7:0]    err_mask, first_err_mask;

  // Behavioural FIFO under observation
  logic [DW-1:0] f_mem [DEPTH];
  int            f_cnt, f_wp, f_rp;
  logic [DW-1:0] f_dout;
  logic          f_ovf, f_udf, f_ack;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      f_cnt <= 0; f_wp <= 0; f_rp <= 0;
      f_dout <= '0; f_ovf <= 1'b0; f_udf <= 1'b0; f_ack <= 1'b0;
    end else begin
      bit w, r;
      w = wr_en && (f_cnt < DEPTH);
      r = rd_en && (f_cnt > 0);
      if (w) begin f_mem[f_wp] <= data_in; f_wp <= (f_wp + 1) % DEPTH; end
      if (r) begin f_dout <= f_mem[f_rp]; f_rp <= (f_rp + 1) % DEPTH; end
      f_cnt <= f_cnt + int'(w) - int'(r);
      f_ack <= w;
      f_ovf <= wr_en && !w;
      f_udf <= rd_en && !r;
    end
  end

  assign data_out    = inj_dout ? 16'hDEAD : f_dout;
  assign overflow    = f_ovf ^ inj_ovf;
  assign underflow   = f_udf;
  assign wr_ack      = f_ack;
  assign full        = (f_cnt == DEPTH);
  assign almostfull  = (f_cnt == DEPTH - 1);
  assign empty       = (f_cnt == 0);
  assign almostempty = (f_cnt == 1);

  fifo_shadow_checker #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .AF_TH     (DEPTH - 1),
    .AE_TH     (1),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .data_out       (data_out),
    .full           (full),
    .almostfull     (almostfull),
    .empty          (empty),
    .almostempty    (almostempty),
    .overflow       (overflow),
    .underflow      (underflow),
    .wr_ack         (wr_ack),
    .chk_en         (chk_en),
    .test_end       (test_end),
    .correct_count  (correct_count),
    .error_count    (error_count),
    .err_valid      (err_valid),
    .err_mask       (err_mask),
    .done           (done),
    .first_err_cycle(first_err_cycle),
    .first_err_mask (first_err_mask)
  );

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;
  exp_t        sb[$];
  bst_e        bst;
  logic [CW-1:0] e_cor, e_err, e_rc, e_fc;
  logic [7:0]    e_fm;
  logic          e_seen;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic bench_clear();
    bst = B_IDLE; e_cor = '0; e_err = '0; e_rc = '0; e_fc = '0; e_fm = '0; e_seen = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; chk_en = 1'b0; test_end = 1'b0;
    inj_dout = 1'b0; inj_ovf = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_err_valid", err_valid, 0);
    check_eq("rst_err_mask", err_mask, 0);
    check_eq("rst_correct", correct_count, 0);
    check_eq("rst_error", error_count, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fe_cycle", first_err_cycle, 0);
    check_eq("rst_fe_mask", first_err_mask, 0);
    bench_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs and faults, queue the expected result, then compare.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic id, input logic io, input logic ce, input logic te);
    exp_t       e, g;
    logic [7:0] m;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d; inj_dout = id; inj_ovf = io;
    chk_en = ce; test_end = te;
    m = '0; m[0] = id; m[5] = io;
    e.ev = 1'b0; e.em = '0;
    if (bst == B_RUN) begin
      if (m == '0) e_cor = e_cor + 1;
      else begin
        e_err = e_err + 1; e.ev = 1'b1; e.em = m;
`ifdef FIFO_CHK_FIRST_ERR_EN
        if (!e_seen) begin e_seen = 1'b1; e_fc = e_rc; e_fm = m; end
`endif
      end
      e_rc = e_rc + 1;
    end
    case (bst)
      B_IDLE:  if (te) bst = B_DONE; else if (ce) bst = B_RUN;
      B_RUN:   if (te) bst = B_DONE;
      default: ;
    endcase
    e.cor = e_cor; e.err = e_err; e.dn = (bst == B_DONE); e.fc = e_fc; e.fm = e_fm;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    check_eq("err_valid", err_valid, g.ev);
    if (g.ev) check_eq("err_mask", err_mask, g.em);
    check_eq("correct_count", correct_count, g.cor);
    check_eq("error_count", error_count, g.err);
    check_eq("done", done, g.dn);
    check_eq("first_err_cycle", first_err_cycle, g.fc);
    check_eq("first_err_mask", first_err_mask, g.fm);
  endtask

  initial begin
    bench_clear();
    do_reset();
    step(0, 0, '0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 1, 0);
    // Read back; the 3rd word is replaced by 0xDEAD on the cycle it appears
    for (int i = 0; i < 8; i++) step(0, 1, '0, (i == 3), 0, 1, 0);
    step(0, 0, '0, 0, 0, 1, 0);
    // Empty with both enables: write only plus underflow
    step(1, 1, 16'h00AA, 0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, DW'(16'h0100 + i), 0, 0, 1, 0);
    // Full with both enables: read only
    step(1, 1, 16'h0BAD, 0, 0, 1, 0);
    step(1, 0, 16'h0C00, 0, 0, 1, 0);
    step(1, 0, 16'h0BAD, 0, 0, 1, 0);
    // Overflow reported as 0 by the FIFO
    step(0, 0, '0, 0, 1, 1, 0);
    for (int i = 0; i < 24; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), DW'($urandom), 0, 0, 1, 0);
    step(0, 1, '0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, DW'(i), 0, (i == 2), 1, 0);
    do_reset();
    step(0, 0, '0, 0, 0, 1, 0);
    step(1, 0, 16'h1111, 0, 0, 1, 0);
    step(0, 1, '0, 0, 0, 1, 0);
    step(0, 0, '0, 0, 1, 1, 0);
    do_reset();
    step(1, 0, 16'h2222, 0, 0, 0, 1);
    step(1, 0, 16'h3333, 0, 1, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
